// File: rtl/icache_responder_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache responder.
interface icache_responder_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              flush;
    logic              ihit;
    logic [31:0]       imemload;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wait;
    logic [31:0]       mem_load;
    logic [31:0]       hit_cnt;
    logic [31:0]       miss_cnt;

    // Environment side: fetch stage plus backing memory.
    modport master (
        output imemREN, imemaddr, flush, mem_wait, mem_load,
        input  ihit, imemload, mem_ren, mem_addr, hit_cnt, miss_cnt
    );

    // Cache side.
    modport slave (
        input  imemREN, imemaddr, flush, mem_wait, mem_load,
        output ihit, imemload, mem_ren, mem_addr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-line, read-only instruction cache.
// Hits answer combinationally; misses run a single-request refill against backing memory.
module icache_responder #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned ADDR_W = 32
) (
    input logic               CLK,
    input logic               nRST,
    icache_responder_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;

    typedef enum logic {StIdle, StRefill} state_t;

    state_t             state_q, state_d;
    // Only the word address of the miss is kept; the byte offset never matters.
    logic [ADDR_W-3:0]  miss_word_q, miss_word_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_arr [SETS];
    logic [31:0]        data_arr [SETS];
    logic [31:0]        hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0]   req_idx, miss_idx;
    logic [TAG_W-1:0]   req_tag, miss_tag;
    logic               hit, grant, miss_start;

    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign req_tag  = bus.imemaddr[ADDR_W-1:IDX_W+2];
    assign miss_idx = miss_word_q[IDX_W-1:0];
    assign miss_tag = miss_word_q[ADDR_W-3:IDX_W];

    assign hit   = (state_q == StIdle) && bus.imemREN && valid_q[req_idx] &&
                   (tag_arr[req_idx] == req_tag) && !bus.flush;
    assign grant = (state_q == StRefill) && !bus.mem_wait;

    // Hit path outputs and counters.
    always_comb begin
        bus.ihit     = hit;
        bus.imemload = hit ? data_arr[req_idx] : '0;
        bus.hit_cnt  = hit_cnt_q;
        bus.miss_cnt = miss_cnt_q;
    end

    // Refill FSM: next state, miss address capture and memory request.
    always_comb begin
        state_d      = state_q;
        miss_word_d  = miss_word_q;
        miss_start   = 1'b0;
        bus.mem_ren  = 1'b0;
        bus.mem_addr = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.imemREN && !hit && !bus.flush) begin
                    state_d     = StRefill;
                    miss_word_d = bus.imemaddr[ADDR_W-1:2];
                    miss_start  = 1'b1;
                end
            end
            StRefill: begin
                bus.mem_ren  = 1'b1;
                bus.mem_addr = {miss_word_q, 2'b00};
                // Address changes and imemREN drops do not abort the refill.
                if (!bus.mem_wait) begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Valid bits: refill grant sets one line, flush clears all and takes priority.
    always_comb begin
        valid_d = valid_q;
        if (grant) begin
            valid_d[miss_idx] = 1'b1;
        end
        if (bus.flush) begin
            valid_d = '0;
        end
    end

    // Control state, valid bits and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StIdle;
            miss_word_q <= '0;
            valid_q     <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_word_q <= miss_word_d;
            valid_q     <= valid_d;
            hit_cnt_q   <= hit_cnt_q + {31'b0, hit};
            miss_cnt_q  <= miss_cnt_q + {31'b0, miss_start};
        end
    end

    // Tag/data storage is written only on a refill grant and needs no reset.
    always_ff @(posedge CLK) begin
        if (grant) begin
            data_arr[miss_idx] <= bus.mem_load;
            tag_arr[miss_idx]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed vector table, hand sequences for
// redirect / flush-on-grant / reset-mid-refill, and a randomized run against a set-of-lines model.
module tb_icache_responder;
    logic CLK;
    logic nRST;

    icache_responder_if #(.ADDR_W(32)) bus ();

    icache_responder #(
        .SETS   (16),
        .ADDR_W (32)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic        use_ovr;
    logic [31:0] ovr_data;

    // Backing memory contents as a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign bus.mem_load = use_ovr ? ovr_data : mem_word(bus.mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a posedge; outputs are checked 1 unit later.
    task automatic put(input logic ren, input logic [31:0] addr, input logic fl,
                       input logic w, input logic [31:0] load);
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.flush    = fl;
        bus.mem_wait = w;
        ovr_data     = load;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        put(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        fl;
        logic        w;
        logic [31:0] load;
        logic        e_hit;
        logic [31:0] e_data;
        logic        e_mren;
        logic [31:0] e_maddr;
    } vec_t;

    vec_t vt [17];

    function automatic vec_t mk(input logic ren, input logic [31:0] addr, input logic fl,
                                input logic w, input logic [31:0] load, input logic e_hit,
                                input logic [31:0] e_data, input logic e_mren,
                                input logic [31:0] e_maddr);
        vec_t v;
        v.ren = ren; v.addr = addr; v.fl = fl; v.w = w; v.load = load;
        v.e_hit = e_hit; v.e_data = e_data; v.e_mren = e_mren; v.e_maddr = e_maddr;
        return v;
    endfunction

    // Random-phase model: which word address each index currently holds.
    logic [29:0] cached [int];
    bit          in_refill;
    logic [31:0] miss_a;
    logic [31:0] m_hits, m_miss;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = (32'($urandom_range(16, 18)) << 6) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        logic [31:0] addr;
        logic        ren, fl, w, e_hit;
        int          idx;

        use_ovr  = 1'b1;
        ovr_data = 32'h0;
        do_reset();

        // Reset state.
        put(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("reset ihit", {31'b0, bus.ihit}, 32'd0);
        chk("reset imemload", bus.imemload, 32'h0);
        chk("reset mem_ren", {31'b0, bus.mem_ren}, 32'd0);
        chk("reset mem_addr", bus.mem_addr, 32'h0);
        chk("reset hit_cnt", bus.hit_cnt, 32'd0);
        chk("reset miss_cnt", bus.miss_cnt, 32'd0);

        // Cold miss with two wait cycles, hits, conflict misses, freeze, flush in idle.
        vt[0]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        vt[1]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b1, 32'h100);
        vt[2]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b1, 32'h100);
        vt[3]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,      1'b1, 32'h100);
        vt[4]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h0,       1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        vt[5]  = mk(1'b1, 32'h101, 1'b0, 1'b1, 32'h0,       1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        vt[6]  = mk(1'b1, 32'h102, 1'b0, 1'b1, 32'h0,       1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        vt[7]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h0,       1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        vt[8]  = mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        vt[9]  = mk(1'b1, 32'h140, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0,      1'b1, 32'h140);
        vt[10] = mk(1'b1, 32'h100, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        vt[11] = mk(1'b1, 32'h104, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0,      1'b1, 32'h100);
        vt[12] = mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        vt[13] = mk(1'b0, 32'h100, 1'b0, 1'b0, 32'h00002222, 1'b0, 32'h0,      1'b1, 32'h140);
        vt[14] = mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h0,       1'b1, 32'h00002222, 1'b0, 32'h0);
        vt[15] = mk(1'b1, 32'h140, 1'b1, 1'b1, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        vt[16] = mk(1'b1, 32'h140, 1'b0, 1'b1, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);

        for (int i = 0; i < 17; i++) begin
            put(vt[i].ren, vt[i].addr, vt[i].fl, vt[i].w, vt[i].load);
            chk($sformatf("vec%0d ihit", i), {31'b0, bus.ihit}, {31'b0, vt[i].e_hit});
            chk($sformatf("vec%0d imemload", i), bus.imemload, vt[i].e_data);
            chk($sformatf("vec%0d mem_ren", i), {31'b0, bus.mem_ren}, {31'b0, vt[i].e_mren});
            chk($sformatf("vec%0d mem_addr", i), bus.mem_addr, vt[i].e_maddr);
            tick();
        end
        chk("table hit_cnt", bus.hit_cnt, 32'd5);
        chk("table miss_cnt", bus.miss_cnt, 32'd5);

        // Redirect mid-refill; 0x304 sits in a different index so 0x200 survives.
        do_reset();
        put(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        tick();
        put(1'b1, 32'h304, 1'b0, 1'b1, 32'h0);
        chk("redir mem_addr wait", bus.mem_addr, 32'h200);
        tick();
        put(1'b1, 32'h304, 1'b0, 1'b0, 32'h0000_2000);
        chk("redir mem_addr grant", bus.mem_addr, 32'h200);
        tick();
        put(1'b1, 32'h304, 1'b0, 1'b1, 32'h0);
        chk("redir new addr miss", {31'b0, bus.ihit}, 32'd0);
        tick();
        put(1'b1, 32'h304, 1'b0, 1'b0, 32'h0000_3000);
        chk("redir second refill addr", bus.mem_addr, 32'h304);
        tick();
        put(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
        chk("redir old addr hit", {31'b0, bus.ihit}, 32'd1);
        chk("redir old addr data", bus.imemload, 32'h0000_2000);
        tick();
        chk("redir miss_cnt", bus.miss_cnt, 32'd2);

        // Flush coincident with the refill grant.
        do_reset();
        put(1'b1, 32'h504, 1'b0, 1'b0, 32'h0);
        tick();
        put(1'b1, 32'h504, 1'b0, 1'b0, 32'h0000_0055);
        tick();
        put(1'b1, 32'h504, 1'b0, 1'b1, 32'h0);
        chk("flush warm hit", {31'b0, bus.ihit}, 32'd1);
        tick();
        put(1'b1, 32'h400, 1'b0, 1'b1, 32'h0);
        tick();
        put(1'b1, 32'h400, 1'b1, 1'b0, 32'h0000_0044);
        chk("flush grant mem_ren", {31'b0, bus.mem_ren}, 32'd1);
        tick();
        put(1'b1, 32'h400, 1'b0, 1'b1, 32'h0);
        chk("flush line invalid", {31'b0, bus.ihit}, 32'd0);
        chk("flush fsm idle", {31'b0, bus.mem_ren}, 32'd0);
        tick();
        put(1'b1, 32'h400, 1'b0, 1'b0, 32'h0000_0044);
        chk("flush re-refill", {31'b0, bus.mem_ren}, 32'd1);
        tick();
        put(1'b1, 32'h504, 1'b0, 1'b1, 32'h0);
        chk("flush warm line lost", {31'b0, bus.ihit}, 32'd0);
        tick();

        // Asynchronous reset during a refill.
        do_reset();
        put(1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        tick();
        put(1'b1, 32'h600, 1'b0, 1'b0, 32'h0000_0066);
        tick();
        put(1'b1, 32'h604, 1'b0, 1'b1, 32'h0);
        tick();
        put(1'b1, 32'h604, 1'b0, 1'b1, 32'h0);
        chk("rst pre mem_ren", {31'b0, bus.mem_ren}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("rst async mem_ren", {31'b0, bus.mem_ren}, 32'd0);
        chk("rst hit_cnt", bus.hit_cnt, 32'd0);
        chk("rst miss_cnt", bus.miss_cnt, 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        put(1'b1, 32'h600, 1'b0, 1'b1, 32'h0);
        chk("rst warm line lost", {31'b0, bus.ihit}, 32'd0);
        tick();

        // Randomized run against the set-of-lines model.
        use_ovr = 1'b0;
        do_reset();
        cached.delete();
        in_refill = 1'b0;
        miss_a    = 32'h0;
        m_hits    = 32'd0;
        m_miss    = 32'd0;
        addr      = rand_addr();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 4) addr = rand_addr();
            ren = ($urandom_range(0, 9) < 8);
            fl  = ($urandom_range(0, 39) == 0);
            w   = ($urandom_range(0, 1) == 1);
            put(ren, addr, fl, w, 32'h0);

            idx   = int'(addr[5:2]);
            e_hit = !in_refill && ren && !fl && cached.exists(idx) && (cached[idx] == addr[31:2]);
            chk($sformatf("rnd%0d ihit", c), {31'b0, bus.ihit}, {31'b0, e_hit});
            chk($sformatf("rnd%0d imemload", c), bus.imemload, e_hit ? mem_word(addr) : 32'h0);
            chk($sformatf("rnd%0d mem_ren", c), {31'b0, bus.mem_ren}, {31'b0, in_refill});
            chk($sformatf("rnd%0d mem_addr", c), bus.mem_addr,
                in_refill ? {miss_a[31:2], 2'b00} : 32'h0);
            chk($sformatf("rnd%0d hit_cnt", c), bus.hit_cnt, m_hits);
            chk($sformatf("rnd%0d miss_cnt", c), bus.miss_cnt, m_miss);

            if (e_hit) m_hits++;
            if (in_refill) begin
                if (!w) begin
                    if (!fl) cached[int'(miss_a[5:2])] = miss_a[31:2];
                    in_refill = 1'b0;
                end
            end else if (ren && !e_hit && !fl) begin
                in_refill = 1'b1;
                miss_a    = addr;
                m_miss++;
            end
            if (fl) cached.delete();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
